// File: rtl/glyph_readback_pkg.sv
// Shared constants and glyph table for the cell drawer and its readback decoder.
package glyph_readback_pkg;

  localparam int GLYPH_W       = 7;
  localparam int BOX_W         = 9;
  localparam int CONTENT_BITS  = GLYPH_W * GLYPH_W;
  localparam int RING_BITS     = 4 * (BOX_W - 1);
  localparam int CONTENT_IDX_W = $clog2(CONTENT_BITS);
  localparam int RING_IDX_W    = $clog2(RING_BITS);
  localparam int NUM_GLYPHS    = 10;

  localparam logic [8:0] GLYPH_MAX = 9'(GLYPH_W);
  localparam logic [8:0] RING_MAX  = 9'(BOX_W - 1);

  localparam logic [2:0] COL_WHITE = 3'b111;
  localparam logic [2:0] COL_RED   = 3'b100;
  localparam logic [2:0] COL_BLACK = 3'b000;

  localparam logic [3:0] CODE_BLANK   = 4'hA;
  localparam logic [3:0] CODE_NOMATCH = 4'hF;

  localparam logic [0:0] ST_CAPTURE = 1'b0;
  localparam logic [0:0] ST_DECODE  = 1'b1;

  // Rows are given top to bottom; row r lands at bits [r*7 +: 7], column c at bit c of the row.
  function automatic logic [CONTENT_BITS-1:0] pack_rows(
    input logic [6:0] r0, input logic [6:0] r1, input logic [6:0] r2, input logic [6:0] r3,
    input logic [6:0] r4, input logic [6:0] r5, input logic [6:0] r6);
    pack_rows = {r6, r5, r4, r3, r2, r1, r0};
  endfunction

  // Content glyph for each digit code; anything outside 0-9 draws as blank.
  function automatic logic [CONTENT_BITS-1:0] glyph_bitmap(input logic [3:0] code);
    case (code)
      4'd0: glyph_bitmap = pack_rows(7'b0011100, 7'b0100010, 7'b0100110, 7'b0101010, 7'b0110010, 7'b0100010, 7'b0011100);
      4'd1: glyph_bitmap = pack_rows(7'b0001000, 7'b0011000, 7'b0001000, 7'b0001000, 7'b0001000, 7'b0001000, 7'b0011100);
      4'd2: glyph_bitmap = pack_rows(7'b0011100, 7'b0100010, 7'b0000010, 7'b0000100, 7'b0001000, 7'b0010000, 7'b0111110);
      4'd3: glyph_bitmap = pack_rows(7'b0111110, 7'b0000100, 7'b0001000, 7'b0000100, 7'b0000010, 7'b0100010, 7'b0011100);
      4'd4: glyph_bitmap = pack_rows(7'b0000100, 7'b0001100, 7'b0010100, 7'b0100100, 7'b0111110, 7'b0000100, 7'b0000100);
      4'd5: glyph_bitmap = pack_rows(7'b0111110, 7'b0100000, 7'b0111100, 7'b0000010, 7'b0000010, 7'b0100010, 7'b0011100);
      4'd6: glyph_bitmap = pack_rows(7'b0001100, 7'b0010000, 7'b0100000, 7'b0111100, 7'b0100010, 7'b0100010, 7'b0011100);
      4'd7: glyph_bitmap = pack_rows(7'b0111110, 7'b0000010, 7'b0000100, 7'b0001000, 7'b0010000, 7'b0010000, 7'b0010000);
      4'd8: glyph_bitmap = pack_rows(7'b0011100, 7'b0100010, 7'b0100010, 7'b0011100, 7'b0100010, 7'b0100010, 7'b0011100);
      4'd9: glyph_bitmap = pack_rows(7'b0011100, 7'b0100010, 7'b0100010, 7'b0011110, 7'b0000010, 7'b0000100, 7'b0011000);
      default: glyph_bitmap = '0;
    endcase
  endfunction

endpackage

// File: rtl/glyph_readback_match.sv
// Combinational lookup of a captured content bitmap against the digit glyph table.
module glyph_match
  import glyph_readback_pkg::*;
(
  input  logic [CONTENT_BITS-1:0] bitmap,
  output logic                    hit,
  output logic [3:0]              code
);

  // Scan codes 0-9; glyphs are all distinct so at most one can hit.
  always_comb begin
    hit  = 1'b0;
    code = 4'd0;
    for (int k = 0; k < NUM_GLYPHS; k++) begin
      if (!hit && (bitmap == glyph_bitmap(4'(k)))) begin
        hit  = 1'b1;
        code = 4'(k);
      end
    end
  end

endmodule

// File: rtl/glyph_readback.sv
// Taps the pixel-plot stream, rebuilds one cell's glyph and border ring, and decodes them.
module glyph_readback
  import glyph_readback_pkg::*;
#(
  parameter int SIZE = 4
) (
  input  logic            clock,
  input  logic            resetn,
  input  logic            clear,
  input  logic [SIZE-1:0] box_x,
  input  logic [SIZE-1:0] box_y,
  input  logic [7:0]      x_in,
  input  logic [6:0]      y_in,
  input  logic [2:0]      colour_in,
  input  logic            plot_in,
  output logic [3:0]      state_out,
  output logic            state_valid,
  output logic            glyph_err,
  output logic            cursor_out,
  output logic            cursor_valid,
  output logic            border_err
);

  logic [8:0]               dx, dy;
  logic                     content_hit, ring_hit;
  logic [CONTENT_IDX_W-1:0] content_idx;
  logic [RING_IDX_W-1:0]    ring_idx;

  logic [0:0]              c_state_q, c_state_d;
  logic [CONTENT_BITS-1:0] c_mask_q, c_mask_d;
  logic [CONTENT_BITS-1:0] c_bitmap_q, c_bitmap_d;
  logic [3:0]              state_out_q, state_out_d;
  logic                    state_valid_q, state_valid_d;
  logic                    glyph_err_q, glyph_err_d;

  logic [0:0]           r_state_q, r_state_d;
  logic [RING_BITS-1:0] r_mask_q, r_mask_d;
  logic [RING_BITS-1:0] r_red_q, r_red_d;
  logic [RING_BITS-1:0] r_white_q, r_white_d;
  logic                 cursor_out_q, cursor_out_d;
  logic                 cursor_valid_q, cursor_valid_d;
  logic                 border_err_q, border_err_d;

  logic       match_hit;
  logic [3:0] match_code;

  glyph_match u_match (
    .bitmap (c_bitmap_q),
    .hit    (match_hit),
    .code   (match_code)
  );

  // Locate the plotted pixel relative to the watched cell; negative offsets wrap and fall out of range.
  always_comb begin
    dx          = {1'b0, x_in} - {{(9-SIZE){1'b0}}, box_x};
    dy          = {2'b0, y_in} - {{(9-SIZE){1'b0}}, box_y};
    content_hit = (dx >= 9'd1) && (dx <= GLYPH_MAX) && (dy >= 9'd1) && (dy <= GLYPH_MAX);
    ring_hit    = (dx <= RING_MAX) && (dy <= RING_MAX) &&
                  ((dx == 9'd0) || (dx == RING_MAX) || (dy == 9'd0) || (dy == RING_MAX));
    content_idx = (dy[CONTENT_IDX_W-1:0] - 6'd1) * 6'(GLYPH_W) + (dx[CONTENT_IDX_W-1:0] - 6'd1);
    ring_idx    = '0;
    if (dy == 9'd0)
      ring_idx = dx[RING_IDX_W-1:0];
    else if (dy == RING_MAX)
      ring_idx = 5'd9 + dx[RING_IDX_W-1:0];
    else if (dx == 9'd0)
      ring_idx = 5'd17 + dy[RING_IDX_W-1:0];
    else
      ring_idx = 5'd24 + dy[RING_IDX_W-1:0];
  end

  // Content capture/decode: collect all 49 pixels, spend one cycle in DECODE, then publish the code.
  always_comb begin
    c_state_d     = c_state_q;
    c_mask_d      = c_mask_q;
    c_bitmap_d    = c_bitmap_q;
    state_out_d   = state_out_q;
    state_valid_d = 1'b0;
    glyph_err_d   = glyph_err_q;
    if (clear) begin
      c_state_d = ST_CAPTURE;
      c_mask_d  = '0;
    end else begin
      if (plot_in && content_hit) begin
        c_bitmap_d[content_idx] = (colour_in == COL_WHITE);
        c_mask_d[content_idx]   = 1'b1;
      end
      case (c_state_q)
        ST_CAPTURE: begin
          if (&c_mask_d) begin
            c_state_d = ST_DECODE;
            c_mask_d  = '0;
          end
        end
        default: begin
          c_state_d     = ST_CAPTURE;
          state_valid_d = 1'b1;
          if (c_bitmap_q == '0) begin
            state_out_d = CODE_BLANK;
            glyph_err_d = 1'b0;
          end else if (match_hit) begin
            state_out_d = match_code;
            glyph_err_d = 1'b0;
          end else begin
            state_out_d = CODE_NOMATCH;
            glyph_err_d = 1'b1;
          end
        end
      endcase
    end
  end

  // Border capture/decode: the ring must be uniformly red (cursor) or uniformly white (no cursor).
  always_comb begin
    r_state_d      = r_state_q;
    r_mask_d       = r_mask_q;
    r_red_d        = r_red_q;
    r_white_d      = r_white_q;
    cursor_out_d   = cursor_out_q;
    cursor_valid_d = 1'b0;
    border_err_d   = border_err_q;
    if (clear) begin
      r_state_d = ST_CAPTURE;
      r_mask_d  = '0;
    end else begin
      if (plot_in && ring_hit) begin
        r_red_d[ring_idx]   = (colour_in == COL_RED);
        r_white_d[ring_idx] = (colour_in == COL_WHITE);
        r_mask_d[ring_idx]  = 1'b1;
      end
      case (r_state_q)
        ST_CAPTURE: begin
          if (&r_mask_d) begin
            r_state_d = ST_DECODE;
            r_mask_d  = '0;
          end
        end
        default: begin
          r_state_d      = ST_CAPTURE;
          cursor_valid_d = 1'b1;
          cursor_out_d   = &r_red_q;
          border_err_d   = !(&r_red_q) && !(&r_white_q);
        end
      endcase
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      c_state_q      <= ST_CAPTURE;
      c_mask_q       <= '0;
      c_bitmap_q     <= '0;
      state_out_q    <= '0;
      state_valid_q  <= 1'b0;
      glyph_err_q    <= 1'b0;
      r_state_q      <= ST_CAPTURE;
      r_mask_q       <= '0;
      r_red_q        <= '0;
      r_white_q      <= '0;
      cursor_out_q   <= 1'b0;
      cursor_valid_q <= 1'b0;
      border_err_q   <= 1'b0;
    end else begin
      c_state_q      <= c_state_d;
      c_mask_q       <= c_mask_d;
      c_bitmap_q     <= c_bitmap_d;
      state_out_q    <= state_out_d;
      state_valid_q  <= state_valid_d;
      glyph_err_q    <= glyph_err_d;
      r_state_q      <= r_state_d;
      r_mask_q       <= r_mask_d;
      r_red_q        <= r_red_d;
      r_white_q      <= r_white_d;
      cursor_out_q   <= cursor_out_d;
      cursor_valid_q <= cursor_valid_d;
      border_err_q   <= border_err_d;
    end
  end

  assign state_out    = state_out_q;
  assign state_valid  = state_valid_q;
  assign glyph_err    = glyph_err_q;
  assign cursor_out   = cursor_out_q;
  assign cursor_valid = cursor_valid_q;
  assign border_err   = border_err_q;

endmodule

// File: tb/tb_glyph_readback.sv
// Directed self-checking bench for glyph_readback.
module tb_glyph_readback;

  logic       clock = 1'b0;
  logic       resetn, clear;
  logic [3:0] box_x, box_y;
  logic [7:0] x_in;
  logic [6:0] y_in;
  logic [2:0] colour_in;
  logic       plot_in;
  logic [3:0] state_out;
  logic       state_valid, glyph_err, cursor_out, cursor_valid, border_err;

  // Hand-written copies of the glyphs used here, bottom row first in each concatenation.
  localparam logic [48:0] G1 = {7'b0011100, 7'b0001000, 7'b0001000, 7'b0001000, 7'b0001000, 7'b0011000, 7'b0001000};
  localparam logic [48:0] G3 = {7'b0011100, 7'b0100010, 7'b0000010, 7'b0000100, 7'b0001000, 7'b0000100, 7'b0111110};
  localparam logic [48:0] G5 = {7'b0011100, 7'b0100010, 7'b0000010, 7'b0000010, 7'b0111100, 7'b0100000, 7'b0111110};
  localparam logic [48:0] G8 = {7'b0011100, 7'b0100010, 7'b0100010, 7'b0011100, 7'b0100010, 7'b0100010, 7'b0011100};

  int tests_run    = 0;
  int tests_failed = 0;
  int s_pulses     = 0;
  int c_pulses     = 0;
  int p;

  glyph_readback #(.SIZE(4)) dut (
    .clock        (clock),
    .resetn       (resetn),
    .clear        (clear),
    .box_x        (box_x),
    .box_y        (box_y),
    .x_in         (x_in),
    .y_in         (y_in),
    .colour_in    (colour_in),
    .plot_in      (plot_in),
    .state_out    (state_out),
    .state_valid  (state_valid),
    .glyph_err    (glyph_err),
    .cursor_out   (cursor_out),
    .cursor_valid (cursor_valid),
    .border_err   (border_err)
  );

  always #5 clock = ~clock;

  // Count valid pulses; sampled at posedge so the value seen is the one from the cycle just ending.
  always @(posedge clock) begin
    if (state_valid) s_pulses++;
    if (cursor_valid) c_pulses++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] x, input logic [6:0] y, input logic [2:0] col);
    @(negedge clock);
    x_in      = x;
    y_in      = y;
    colour_in = col;
    plot_in   = 1'b1;
  endtask

  task automatic idle();
    @(negedge clock);
    plot_in = 1'b0;
    clear   = 1'b0;
  endtask

  task automatic sendContent(input logic [48:0] bmp, input int first, input int count, input int skip);
    for (int i = first; i < first + count; i++) begin
      if (i != skip)
        applyStimulus(8'(box_x) + 8'(i % 7 + 1), 7'(box_y) + 7'(i / 7 + 1), bmp[i] ? 3'b111 : 3'b000);
    end
  endtask

  task automatic sendRing(input logic [2:0] col, input int odd, input logic [2:0] odd_col);
    int k;
    k = 0;
    for (int dy = 0; dy < 9; dy++) begin
      for (int dx = 0; dx < 9; dx++) begin
        if (dx == 0 || dx == 8 || dy == 0 || dy == 8) begin
          applyStimulus(8'(box_x) + 8'(dx), 7'(box_y) + 7'(dy), (k == odd) ? odd_col : col);
          k++;
        end
      end
    end
  endtask

  task automatic expectContent(input logic [3:0] code, input logic err, input string tag);
    idle();
    checkOutput({tag, "_decode_cycle_valid"}, 32'(state_valid), 32'd0);
    idle();
    checkOutput({tag, "_valid"}, 32'(state_valid), 32'd1);
    checkOutput({tag, "_code"}, 32'(state_out), 32'(code));
    checkOutput({tag, "_glyph_err"}, 32'(glyph_err), 32'(err));
  endtask

  task automatic expectRing(input logic cur, input logic err, input string tag);
    idle();
    checkOutput({tag, "_decode_cycle_valid"}, 32'(cursor_valid), 32'd0);
    idle();
    checkOutput({tag, "_valid"}, 32'(cursor_valid), 32'd1);
    checkOutput({tag, "_cursor"}, 32'(cursor_out), 32'(cur));
    checkOutput({tag, "_border_err"}, 32'(border_err), 32'(err));
  endtask

  initial begin
    resetn = 1'b0; clear = 1'b0; plot_in = 1'b0;
    x_in = '0; y_in = '0; colour_in = '0;
    box_x = 4'd1; box_y = 4'd1;
    repeat (3) @(negedge clock);
    checkOutput("rst_state_out", 32'(state_out), 32'd0);
    checkOutput("rst_state_valid", 32'(state_valid), 32'd0);
    checkOutput("rst_glyph_err", 32'(glyph_err), 32'd0);
    checkOutput("rst_cursor_out", 32'(cursor_out), 32'd0);
    checkOutput("rst_cursor_valid", 32'(cursor_valid), 32'd0);
    checkOutput("rst_border_err", 32'(border_err), 32'd0);
    resetn = 1'b1;

    // T1-T3: full glyphs, blank, and a corrupted 8.
    sendContent(G3, 0, 49, -1);
    expectContent(4'd3, 1'b0, "t1");
    sendContent(49'd0, 0, 49, -1);
    expectContent(4'hA, 1'b0, "t2");
    sendContent(G8 ^ (49'd1 << 24), 0, 49, -1);
    expectContent(4'hF, 1'b1, "t3");
    idle();
    checkOutput("t3_pulse_count", 32'(s_pulses), 32'd3);

    // T4: ring colour cases.
    p = s_pulses;
    sendRing(3'b100, -1, 3'b100);
    expectRing(1'b1, 1'b0, "t4_red");
    sendRing(3'b111, -1, 3'b111);
    expectRing(1'b0, 1'b0, "t4_white");
    sendRing(3'b100, 13, 3'b111);
    expectRing(1'b0, 1'b1, "t4_mixed");
    sendRing(3'b100, -1, 3'b100);
    expectRing(1'b1, 1'b0, "t4_red_again");
    idle();
    checkOutput("t4_cursor_pulses", 32'(c_pulses), 32'd4);
    checkOutput("t4_no_content_pulse", 32'(s_pulses), 32'(p));
    checkOutput("t4_state_out_kept", 32'(state_out), 32'hF);

    // T5: out-of-cell plots and a duplicate write where the second value wins.
    p = s_pulses;
    applyStimulus(8'd0, 7'd0, 3'b111);
    applyStimulus(8'd20, 7'd20, 3'b111);
    applyStimulus(8'd3, 7'd3, 3'b111);
    applyStimulus(8'd3, 7'd3, 3'b000);
    repeat (4) idle();
    checkOutput("t5_no_early_valid", 32'(s_pulses), 32'(p));
    sendContent(G1, 0, 49, 8);
    expectContent(4'd1, 1'b0, "t5");

    // T6: reset mid-capture.
    idle();
    p = s_pulses;
    sendContent(G3, 19, 30, -1);
    @(negedge clock);
    plot_in = 1'b0; resetn = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
    checkOutput("t6_rst_state_out", 32'(state_out), 32'd0);
    checkOutput("t6_rst_cursor_out", 32'(cursor_out), 32'd0);
    checkOutput("t6_rst_glyph_err", 32'(glyph_err), 32'd0);
    repeat (3) idle();
    checkOutput("t6_rst_no_pulse", 32'(s_pulses), 32'(p));
    sendContent(G5, 0, 49, -1);
    expectContent(4'd5, 1'b0, "t6_reset");

    // T6: clear mid-capture keeps the published outputs.
    idle();
    p = s_pulses;
    sendContent(G3, 19, 30, -1);
    @(negedge clock);
    plot_in = 1'b0; clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    checkOutput("t6_clr_state_out_kept", 32'(state_out), 32'd5);
    checkOutput("t6_clr_cursor_kept", 32'(cursor_out), 32'd0);
    repeat (3) idle();
    checkOutput("t6_clr_no_pulse", 32'(s_pulses), 32'(p));
    sendContent(G8, 0, 49, -1);
    expectContent(4'd8, 1'b0, "t6_clear");

    // T7: a plot landing in the DECODE cycle starts the next capture.
    sendContent(G5, 0, 49, -1);
    @(negedge clock);
    checkOutput("t7_decode_cycle_valid", 32'(state_valid), 32'd0);
    x_in = 8'd2; y_in = 7'd2; colour_in = G1[0] ? 3'b111 : 3'b000; plot_in = 1'b1;
    @(negedge clock);
    plot_in = 1'b0;
    checkOutput("t7_first_valid", 32'(state_valid), 32'd1);
    checkOutput("t7_first_code", 32'(state_out), 32'd5);
    sendContent(G1, 1, 48, -1);
    expectContent(4'd1, 1'b0, "t7_next");
    idle();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
